// File: rtl/ddr_ui_pkg.sv
// Shared types and constants for the DDR3 UI responder model.
package ddr_ui_pkg;
  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam int         UI_DW        = 256;
  localparam int         UI_MW        = 32;
  localparam int         ADDRESS_UNIT = 8;
  localparam int         UI_AW        = 30;
  localparam int         FIFO_DEPTH   = 4;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [UI_AW-1:0] addr;
  } ui_cmd_t;

  typedef struct packed {
    logic [UI_DW-1:0] data;
    logic [UI_MW-1:0] mask;
  } ui_wdat_t;

  typedef enum logic {S_CAL, S_RUN} ui_state_t;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction
endpackage

// File: rtl/ddr3_ui_responder_fifo.sv
// Small synchronous FIFO with registered occupancy; dout shows the head entry.
module ui_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Storage array; not reset, only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ddr3_ui_responder.sv
// Behavioural DDR3 UI slave: command/data FIFOs, in-order executor,
// byte-masked BRAM and a fixed-latency read return pipe.
module ddr3_ui_responder
  import ddr_ui_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int RD_LAT     = 4,
  parameter int CAL_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_en,
  output logic             calib_done,
  input  logic             app_en,
  input  logic [2:0]       app_cmd,
  input  logic [UI_AW-1:0] app_addr,
  output logic             app_rdy,
  input  logic             app_wdf_wren,
  input  logic             app_wdf_end,
  input  logic [UI_DW-1:0] app_wdf_data,
  input  logic [UI_MW-1:0] app_wdf_mask,
  output logic             app_wdf_rdy,
  output logic [UI_DW-1:0] app_rd_data,
  output logic             app_rd_data_valid,
  output logic             app_rd_data_end,
  output logic             err_cmd
);
  localparam int STAGES = RD_LAT - 1;
  localparam int IDX_LO = $clog2(ADDRESS_UNIT);
  localparam int CAL_W  = $clog2(CAL_CYCLES + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  ui_state_t        state, state_nxt;
  logic [CAL_W-1:0] cal_cnt;
  logic [2:0]       stall_cnt;

  ui_cmd_t          cq_din, cq_head;
  ui_wdat_t         dq_din, dq_head;
  logic             cq_full, cq_empty, dq_full, dq_empty, cq_pop;
  logic [CNT_W-1:0] cq_cnt, dq_cnt;
  logic             exec_wr, exec_rd, exec_ill;
  logic [MEM_AW-1:0] mem_idx;

  logic [UI_DW-1:0]             mem [2**MEM_AW];
  logic [UI_DW-1:0]             bram_q;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:1][UI_DW-1:0]   dat_pipe;

  // Calibration state and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_CAL;
      cal_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CAL) cal_cnt <= cal_cnt + 1'b1;
    end
  end

  // Leave calibration after CAL_CYCLES cycles; S_RUN is terminal.
  always_comb begin
    state_nxt  = state;
    calib_done = 1'b0;
    case (state)
      S_CAL:   if (cal_cnt == CAL_W'(CAL_CYCLES-1)) state_nxt = S_RUN;
      S_RUN:   calib_done = 1'b1;
      default: state_nxt = S_CAL;
    endcase
  end

  // Free-running counter that paces the optional back-pressure pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else       stall_cnt <= stall_cnt + 3'd1;
  end

  assign app_rdy     = calib_done && !cq_full  && !(stall_en && stall_cnt[1:0] == 2'b11);
  assign app_wdf_rdy = calib_done && !dq_full  && !(stall_en && stall_cnt == 3'b101);

  assign cq_din = '{cmd: app_cmd, addr: app_addr};
  assign dq_din = '{data: app_wdf_data, mask: app_wdf_mask};

  ui_sync_fifo #(.W($bits(ui_cmd_t)), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(app_en && app_rdy), .din(cq_din),
    .pop(cq_pop), .dout(cq_head), .full(cq_full), .empty(cq_empty), .count(cq_cnt)
  );

  ui_sync_fifo #(.W($bits(ui_wdat_t)), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clk(clk), .reset(reset), .push(app_wdf_wren && app_wdf_rdy), .din(dq_din),
    .pop(exec_wr), .dout(dq_head), .full(dq_full), .empty(dq_empty), .count(dq_cnt)
  );

  // A head write waits for its beat; reads and illegal commands never wait.
  assign exec_wr  = !cq_empty && (cq_head.cmd == CMD_WRITE) && !dq_empty;
  assign exec_rd  = !cq_empty && (cq_head.cmd == CMD_READ);
  assign exec_ill = !cq_empty && !is_legal(cq_head.cmd);
  assign cq_pop   = exec_wr || exec_rd || exec_ill;
  assign mem_idx  = cq_head.addr[MEM_AW+IDX_LO-1:IDX_LO];

  // Byte-enabled BRAM with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (exec_wr)
      for (int i = 0; i < UI_MW; i++)
        if (!dq_head.mask[i]) mem[mem_idx][i*8 +: 8] <= dq_head.data[i*8 +: 8];
    if (exec_rd) bram_q <= mem[mem_idx];
  end

  // Read return pipe; data is zeroed outside valid slots so idle output is 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], exec_rd};
      dat_pipe[1] <= vld_pipe[0] ? bram_q : '0;
      for (int k = 2; k <= STAGES; k++) dat_pipe[k] <= dat_pipe[k-1];
    end
  end

  assign app_rd_data       = dat_pipe[STAGES];
  assign app_rd_data_valid = vld_pipe[STAGES];
  assign app_rd_data_end   = vld_pipe[STAGES];

  // Sticky flag for any illegal command that reached the executor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_cmd <= 1'b0;
    else if (exec_ill) err_cmd <= 1'b1;
  end

  logic unused;
  assign unused = ^{app_wdf_end, cq_head.addr, cq_cnt, dq_cnt};
endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Directed + randomized bench for ddr3_ui_responder with an ordered-retire model.
module tb_ddr3_ui_responder;
  import ddr_ui_pkg::*;
  localparam int MEM_AW = 10, RD_LAT = 4, CAL_CYCLES = 64, LIM = 200;

  logic clk = 1'b0, reset = 1'b1, stall_en = 1'b0;
  logic app_en = 1'b0, app_wdf_wren = 1'b0, app_wdf_end = 1'b0;
  logic [2:0]   app_cmd = '0;
  logic [29:0]  app_addr = '0;
  logic [255:0] app_wdf_data = '0;
  logic [31:0]  app_wdf_mask = '0;
  logic calib_done, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, err_cmd;
  logic [255:0] app_rd_data;

  ddr3_ui_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .CAL_CYCLES(CAL_CYCLES)) dut (
    .clk(clk), .reset(reset), .stall_en(stall_en), .calib_done(calib_done),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;
  int acc_cyc, last_cyc;
  logic [255:0] last_obs;

  // Reference model: memory image plus queues of accepted commands and beats.
  logic [255:0] mdl [1024];
  bit           mdl_err = 1'b0;
  int           op_kind[$];
  int           op_idx[$];
  logic [255:0] bq_d[$];
  logic [31:0]  bq_m[$];
  logic [255:0] exp_q[$];
  logic [255:0] obs_q[$];
  bit           obs_end[$];
  int           obs_cyc[$];

  // Capture every read return with the cycle it appeared in.
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      obs_q.push_back(app_rd_data);
      obs_end.push_back(app_rd_data_end);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic int idx_of(input logic [29:0] a);
    return (int'(a) / 8) % (1 << MEM_AW);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire model commands in acceptance order; a write needs a beat first.
  task automatic retire();
    logic [255:0] d;
    logic [31:0]  m;
    while (op_kind.size() > 0) begin
      if (op_kind[0] == 0) begin
        if (bq_d.size() == 0) break;
        d = bq_d.pop_front();
        m = bq_m.pop_front();
        for (int b = 0; b < 32; b++) if (!m[b]) mdl[op_idx[0]][b*8 +: 8] = d[b*8 +: 8];
      end else if (op_kind[0] == 1) begin
        exp_q.push_back(mdl[op_idx[0]]);
      end else begin
        mdl_err = 1'b1;
      end
      op_kind.delete(0);
      op_idx.delete(0);
    end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [29:0] a);
    int n = 0;
    app_en = 1'b1; app_cmd = c; app_addr = a; #1;
    while (!app_rdy && n < LIM) begin @(negedge clk); #1; n++; end
    chk("cmd_handshake", 256'(n < LIM), 256'(1));
    @(negedge clk);
    acc_cyc = cyc; app_en = 1'b0;
    op_kind.push_back((c == CMD_WRITE) ? 0 : (c == CMD_READ) ? 1 : 2);
    op_idx.push_back(idx_of(a));
    retire();
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] m);
    int n = 0;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m; #1;
    while (!app_wdf_rdy && n < LIM) begin @(negedge clk); #1; n++; end
    chk("beat_handshake", 256'(n < LIM), 256'(1));
    @(negedge clk);
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    bq_d.push_back(d); bq_m.push_back(m);
    retire();
  endtask

  task automatic wr(input logic [29:0] a, input logic [255:0] d, input logic [31:0] m, input bit beat_first);
    if (beat_first) begin send_beat(d, m); send_cmd(CMD_WRITE, a); end
    else            begin send_cmd(CMD_WRITE, a); send_beat(d, m); end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin @(negedge clk); n++; end
    repeat (RD_LAT + 2) @(negedge clk);
    chk({tag, "_count"}, 256'(obs_q.size()), 256'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      last_cyc = obs_cyc.pop_front();
      chk({tag, "_end"}, 256'(obs_end.pop_front()), 256'(1));
      last_obs = obs_q.pop_front();
      chk({tag, "_data"}, last_obs, exp_q.pop_front());
    end
    exp_q.delete(); obs_q.delete(); obs_end.delete(); obs_cyc.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_calib"},   256'(calib_done), 256'(0));
    chk({tag, "_rdy"},     256'(app_rdy), 256'(0));
    chk({tag, "_wdf_rdy"}, 256'(app_wdf_rdy), 256'(0));
    chk({tag, "_valid"},   256'(app_rd_data_valid), 256'(0));
    chk({tag, "_end"},     256'(app_rd_data_end), 256'(0));
    chk({tag, "_data"},    app_rd_data, 256'(0));
    chk({tag, "_err"},     256'(err_cmd), 256'(0));
  endtask

  initial begin
    logic [255:0] d, d2;
    logic [29:0]  a;
    logic [31:0]  m;
    int rd_acc;

    // Reset values and calibration timing.
    repeat (3) @(negedge clk); #1;
    chk_reset_outs("rst");
    @(negedge clk); reset = 1'b0;
    repeat (CAL_CYCLES - 1) @(posedge clk); #1;
    chk("calib_pre", 256'(calib_done), 256'(0));
    chk("rdy_pre", 256'(app_rdy), 256'(0));
    @(posedge clk); #1;
    chk("calib_rise", 256'(calib_done), 256'(1));
    chk("rdy_rise", 256'(app_rdy), 256'(1));
    @(negedge clk);

    // Basic write/read with latency measurement.
    wr(30'h100, {32{8'hA5}}, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    send_cmd(CMD_READ, 30'h100); rd_acc = acc_cyc;
    drain("raw_a5");
    chk("raw_a5_const", last_obs, {32{8'hA5}});
    chk("rd_latency", 256'(last_cyc - rd_acc), 256'(RD_LAT));

    // Byte mask: only byte 0 written over a zero word.
    wr(30'h8, 256'h0, 32'h0, 1'b0);
    wr(30'h8, {32{8'hFF}}, 32'hFFFF_FFFE, 1'b1);
    send_cmd(CMD_READ, 30'h8);
    drain("mask");
    chk("mask_const", last_obs, 256'hFF);

    // Data after its command, with a read queued behind the write.
    d = rnd256();
    send_cmd(CMD_WRITE, 30'h20);
    send_cmd(CMD_READ, 30'h20);
    repeat (5) @(negedge clk);
    send_beat(d, 32'h0);
    drain("late_data");
    chk("late_data_const", last_obs, d);

    // Data before its command.
    d = rnd256(); d2 = rnd256();
    send_beat(d, 32'h0); send_beat(d2, 32'h0);
    send_cmd(CMD_WRITE, 30'h28); send_cmd(CMD_WRITE, 30'h30);
    send_cmd(CMD_READ, 30'h28);  send_cmd(CMD_READ, 30'h30);
    drain("early_data");

    // Sixteen writes then sixteen reads under back-pressure.
    stall_en = 1'b1;
    for (int i = 0; i < 16; i++) wr(30'(i * 8), rnd256(), 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) send_cmd(CMD_READ, 30'(i * 8));
    drain("stall16");
    stall_en = 1'b0;

    // Address aliasing above the memory index.
    d = rnd256();
    wr(30'h2000, d, 32'h0, 1'b0);
    send_cmd(CMD_READ, 30'h0);
    drain("alias");
    chk("alias_const", last_obs, d);

    // Illegal command: flag set, memory untouched.
    chk("err_pre", 256'(err_cmd), 256'(0));
    send_cmd(3'b011, 30'h0);
    send_cmd(CMD_READ, 30'h0);
    drain("illegal");
    chk("illegal_mem", last_obs, d);
    chk("err_set", 256'(err_cmd), 256'(mdl_err));

    // Randomized traffic over indices 0..15 with random upper/lower address bits.
    for (int t = 0; t < 80; t++) begin
      stall_en = 1'($urandom_range(0, 1));
      a = 30'($urandom);
      a[12:3] = 10'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: send_cmd(3'($urandom_range(2, 7)), a);
        1, 2, 3, 4: begin
          m = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'($urandom);
          wr(a, rnd256(), m, 1'($urandom_range(0, 1)));
        end
        default: send_cmd(CMD_READ, a);
      endcase
    end
    drain("rand");
    chk("err_sticky", 256'(err_cmd), 256'(1));
    stall_en = 1'b0;

    // Reset with three reads in flight: nothing returns, memory is kept.
    send_cmd(CMD_READ, 30'h100);
    send_cmd(CMD_READ, 30'h100);
    send_cmd(CMD_READ, 30'h100);
    reset = 1'b1; #1;
    chk_reset_outs("mid_rst");
    exp_q.delete(); op_kind.delete(); op_idx.delete(); bq_d.delete(); bq_m.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (CAL_CYCLES + 16) @(negedge clk);
    chk("post_rst_valid", 256'(obs_q.size()), 256'(0));
    chk("post_rst_idle_data", app_rd_data, 256'(0));
    send_cmd(CMD_READ, 30'h100);
    drain("mem_keep");
    chk("mem_keep_const", last_obs, {32{8'hA5}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
